// File: rtl/wfifo_pixel_packer_if.sv
// -----------------------------------------------------------------------------
// wfifo_pixel_packer_if
//   Bundles the pixel-stream input and the FIFO write-port signals of the
//   wfifo pixel packer.
//   master : the packer (consumes pixels and wr_full, drives wr_en/wr_data)
//   slave  : the surrounding video source plus FIFO write port
// Signals
//   pix_vs    frame sync level, rising edge marks a frame start
//   pix_de    pixel valid, one pixel per cycle while high
//   pix_data  pixel value
//   wr_full   FIFO full flag
//   wr_en     FIFO write enable
//   wr_data   FIFO write word
// -----------------------------------------------------------------------------
interface wfifo_pixel_packer_if #(
   parameter int PIX_WIDTH  = 16,
   parameter int WORD_WIDTH = 32
);
   logic                  pix_vs;
   logic                  pix_de;
   logic [PIX_WIDTH-1:0]  pix_data;
   logic                  wr_full;
   logic                  wr_en;
   logic [WORD_WIDTH-1:0] wr_data;

   modport master (
      input  pix_vs, pix_de, pix_data, wr_full,
      output wr_en, wr_data
   );

   modport slave (
      output pix_vs, pix_de, pix_data, wr_full,
      input  wr_en, wr_data
   );
endinterface

// File: rtl/wfifo_pixel_packer.sv
// -----------------------------------------------------------------------------
// wfifo_pixel_packer
//   Write-side stage in front of the wfifo write port. Packs a non-stallable
//   pixel stream into WORD_WIDTH words (R = WORD_WIDTH/PIX_WIDTH pixels each),
//   aligns the partial word to every frame start and drops completed words
//   that cannot be stored while the FIFO is full, flagging the loss.
// Ports
//   wr_clk       write clock
//   wr_rst       asynchronous active-high reset
//   pif          wfifo_pixel_packer_if.master (pixel stream in, FIFO write out)
//   frame_start  one-cycle pulse the cycle after a pix_vs rising edge
//   wr_word_cnt  words written since the last frame start, saturating
//   ovf_flag     sticky per frame: a completed word was dropped
//   drop_cnt     dropped words this frame, saturating (only with
//                WFIFO_PACK_DROP_CNT_EN defined)
// Configuration
//   `define WFIFO_PACK_DROP_CNT_EN adds the drop_cnt output and its counter.
// -----------------------------------------------------------------------------
module wfifo_pixel_packer #(
   parameter int PIX_WIDTH  = 16,
   parameter int WORD_WIDTH = 32,
   parameter int LSB_FIRST  = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 wr_clk,
   input  logic                 wr_rst,
   wfifo_pixel_packer_if.master pif,
   output logic                 frame_start,
   output logic [CNT_WIDTH-1:0] wr_word_cnt,
   output logic                 ovf_flag
`ifdef WFIFO_PACK_DROP_CNT_EN
   ,
   output logic [15:0]          drop_cnt
`endif
);

   localparam int R     = WORD_WIDTH / PIX_WIDTH;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(R - 1);

   logic                  vs_d;
   logic                  vs_rise;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      lane;
   logic [IDX_W-1:0]      pos;
   logic                  word_done;
   logic [WORD_WIDTH-1:0] asm_q;
   logic [WORD_WIDTH-1:0] asm_next;
   logic [WORD_WIDTH-1:0] hold_data;
   logic                  hold_valid;
   logic                  wr_en_i;
   logic                  hold_load;
   logic                  drop;

   assign vs_rise = pif.pix_vs & ~vs_d;

   // A frame start realigns immediately: a pixel arriving in the vs_rise
   // cycle is lane 0 of the new frame, whatever idx_q held.
   assign lane      = vs_rise ? '0 : idx_q;
   assign pos       = (LSB_FIRST != 0) ? lane : (LAST_LANE - lane);
   assign word_done = pif.pix_de & (lane == LAST_LANE);

   // Writes are gated combinationally by wr_full and suppressed on vs_rise,
   // since the held word belongs to the frame being abandoned.
   assign wr_en_i = hold_valid & ~pif.wr_full & ~vs_rise;

   // The held word is replaced when its slot is free, is being written this
   // cycle, or is being discarded by the frame start. Otherwise the new word
   // is the one that is lost.
   assign hold_load = word_done & (vs_rise | ~hold_valid | wr_en_i);
   assign drop      = word_done & hold_valid & pif.wr_full & ~vs_rise;

   assign pif.wr_en   = wr_en_i;
   assign pif.wr_data = hold_data;

   // NOTE: every always_comb output is given a default before any branch so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      asm_next = vs_rise ? '0 : asm_q;
      if (pif.pix_de) begin
         asm_next[pos*PIX_WIDTH +: PIX_WIDTH] = pif.pix_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         vs_d        <= 1'b0;
         idx_q       <= '0;
         asm_q       <= '0;
         hold_data   <= '0;
         hold_valid  <= 1'b0;
         frame_start <= 1'b0;
         wr_word_cnt <= '0;
         ovf_flag    <= 1'b0;
      end else begin
         vs_d        <= pif.pix_vs;
         frame_start <= vs_rise;
         asm_q       <= asm_next;

         if (pif.pix_de) begin
            idx_q <= (lane == LAST_LANE) ? '0 : lane + IDX_W'(1);
         end else if (vs_rise) begin
            idx_q <= '0;
         end

         if (hold_load) begin
            hold_data  <= asm_next;
            hold_valid <= 1'b1;
         end else if (vs_rise || wr_en_i) begin
            hold_valid <= 1'b0;
         end

         if (vs_rise) begin
            wr_word_cnt <= '0;
         end else if (wr_en_i && (wr_word_cnt != {CNT_WIDTH{1'b1}})) begin
            wr_word_cnt <= wr_word_cnt + CNT_WIDTH'(1);
         end

         if (vs_rise) begin
            ovf_flag <= 1'b0;
         end else if (drop) begin
            ovf_flag <= 1'b1;
         end
      end
   end

`ifdef WFIFO_PACK_DROP_CNT_EN
   // drop is already masked by vs_rise, so a clear always wins.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         drop_cnt <= '0;
      end else if (vs_rise) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wfifo_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_wfifo_pixel_packer
//   Three packer instances share one pixel stream:
//     a : 16b pixels, 32b words, LSB first,  16b word counter
//     b : 16b pixels, 32b words, MSB first,   4b word counter
//     c :  8b pixels, 32b words (R=4), LSB first, 16b word counter
//   A queue-of-pixels reference model predicts every output each cycle,
//   and a few literal expectations pin the model on known sequences.
// -----------------------------------------------------------------------------
module tb_wfifo_pixel_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        vs, de, full;
   logic [15:0] pd;

   always #5 clk = ~clk;

   wfifo_pixel_packer_if #(.PIX_WIDTH(16), .WORD_WIDTH(32)) if_a ();
   wfifo_pixel_packer_if #(.PIX_WIDTH(16), .WORD_WIDTH(32)) if_b ();
   wfifo_pixel_packer_if #(.PIX_WIDTH(8),  .WORD_WIDTH(32)) if_c ();

   assign if_a.pix_vs = vs;  assign if_a.pix_de = de;
   assign if_a.pix_data = pd; assign if_a.wr_full = full;
   assign if_b.pix_vs = vs;  assign if_b.pix_de = de;
   assign if_b.pix_data = pd; assign if_b.wr_full = full;
   assign if_c.pix_vs = vs;  assign if_c.pix_de = de;
   assign if_c.pix_data = pd[7:0]; assign if_c.wr_full = full;

   logic        a_fs, b_fs, c_fs;
   logic [15:0] a_cnt, c_cnt;
   logic [3:0]  b_cnt;
   logic        a_ovf, b_ovf, c_ovf;
   logic [15:0] a_dc, b_dc, c_dc;

`ifndef WFIFO_PACK_DROP_CNT_EN
   assign a_dc = '0;
   assign b_dc = '0;
   assign c_dc = '0;
`endif

   wfifo_pixel_packer #(.PIX_WIDTH(16), .WORD_WIDTH(32), .LSB_FIRST(1), .CNT_WIDTH(16)) dut_a (
      .wr_clk(clk), .wr_rst(rst), .pif(if_a.master),
      .frame_start(a_fs), .wr_word_cnt(a_cnt), .ovf_flag(a_ovf)
`ifdef WFIFO_PACK_DROP_CNT_EN
      , .drop_cnt(a_dc)
`endif
   );

   wfifo_pixel_packer #(.PIX_WIDTH(16), .WORD_WIDTH(32), .LSB_FIRST(0), .CNT_WIDTH(4)) dut_b (
      .wr_clk(clk), .wr_rst(rst), .pif(if_b.master),
      .frame_start(b_fs), .wr_word_cnt(b_cnt), .ovf_flag(b_ovf)
`ifdef WFIFO_PACK_DROP_CNT_EN
      , .drop_cnt(b_dc)
`endif
   );

   wfifo_pixel_packer #(.PIX_WIDTH(8), .WORD_WIDTH(32), .LSB_FIRST(1), .CNT_WIDTH(16)) dut_c (
      .wr_clk(clk), .wr_rst(rst), .pif(if_c.master),
      .frame_start(c_fs), .wr_word_cnt(c_cnt), .ovf_flag(c_ovf)
`ifdef WFIFO_PACK_DROP_CNT_EN
      , .drop_cnt(c_dc)
`endif
   );

   // ---------------------------------------------------------------- checking
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------- model
   // Per instance: pixels collected for the current word, the word waiting
   // for the FIFO, and the per-frame counters.
   int          m_r   [3] = '{2, 2, 4};
   int          m_p   [3] = '{16, 16, 8};
   int          m_lsb [3] = '{1, 0, 1};
   int          m_max [3] = '{65535, 15, 65535};
   logic [15:0] m_pix [3][8];
   int          m_n   [3];
   bit          m_hv  [3];
   logic [31:0] m_hold[3];
   int          m_cnt [3];
   int          m_drop[3];
   bit          m_ovf [3];
   bit          m_fs;
   bit          m_vs_d;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_n[i] = 0; m_hv[i] = 0; m_hold[i] = '0;
         m_cnt[i] = 0; m_drop[i] = 0; m_ovf[i] = 0;
      end
      m_fs = 0;
      m_vs_d = 0;
   endtask

   function automatic logic [31:0] pack_word(input int i);
      logic [31:0] w = '0;
      for (int k = 0; k < m_r[i]; k++) begin
         int slot = (m_lsb[i] != 0) ? k : (m_r[i] - 1 - k);
         for (int b = 0; b < m_p[i]; b++) w[slot*m_p[i] + b] = m_pix[i][k][b];
      end
      return w;
   endfunction

   task automatic step_model();
      bit rise = vs & ~m_vs_d;
      for (int i = 0; i < 3; i++) begin
         bit          en   = m_hv[i] & ~full & ~rise;
         bit          done = 0;
         bit          lost;
         logic [31:0] word = '0;
         if (rise) m_n[i] = 0;
         if (de) begin
            m_pix[i][m_n[i]] = pd & 16'((1 << m_p[i]) - 1);
            m_n[i]++;
            if (m_n[i] == m_r[i]) begin
               done   = 1;
               word   = pack_word(i);
               m_n[i] = 0;
            end
         end
         lost = done & m_hv[i] & full & ~rise;
         if (rise)                            m_cnt[i] = 0;
         else if (en && m_cnt[i] < m_max[i])  m_cnt[i]++;
         if (done && !lost) begin
            m_hold[i] = word; m_hv[i] = 1;
         end else if (rise || en) begin
            m_hv[i] = 0;
         end
         if (rise)      m_ovf[i] = 0;
         else if (lost) m_ovf[i] = 1;
         if (rise)                              m_drop[i] = 0;
         else if (lost && m_drop[i] < 16'hFFFF) m_drop[i]++;
      end
      m_fs   = rise;
      m_vs_d = vs;
   endtask

   task automatic cmp(input int i, input logic en, input logic [31:0] data, input logic fs,
                      input logic [15:0] cnt, input logic ovf, input logic [15:0] dc);
      bit    rise   = vs & ~m_vs_d;
      bit    exp_en = m_hv[i] & ~full & ~rise;
      string tag    = $sformatf("%c", 8'd97 + 8'(i));
      check({tag, ".wr_en"}, 32'(en), 32'(exp_en));
      if (exp_en) check({tag, ".wr_data"}, data, m_hold[i]);
      check({tag, ".frame_start"}, 32'(fs), 32'(m_fs));
      check({tag, ".wr_word_cnt"}, 32'(cnt), 32'(m_cnt[i]));
      check({tag, ".ovf_flag"}, 32'(ovf), 32'(m_ovf[i]));
`ifdef WFIFO_PACK_DROP_CNT_EN
      check({tag, ".drop_cnt"}, 32'(dc), 32'(m_drop[i]));
`else
      if (dc !== 16'd0) check({tag, ".drop_cnt_tied"}, 32'(dc), 32'd0);
`endif
   endtask

   task automatic compare_all();
      cmp(0, if_a.wr_en, if_a.wr_data, a_fs, a_cnt, a_ovf, a_dc);
      cmp(1, if_b.wr_en, if_b.wr_data, b_fs, 16'(b_cnt), b_ovf, b_dc);
      cmp(2, if_c.wr_en, if_c.wr_data, c_fs, c_cnt, c_ovf, c_dc);
   endtask

   // Inputs change on the falling edge; outputs are compared 1 ns later.
   task automatic cycle(input logic v, input logic d, input logic [15:0] p, input logic f);
      @(negedge clk);
      vs = v; de = d; pd = p; full = f;
      #1;
      compare_all();
      step_model();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0; vs = 1'b0; de = 1'b0; pd = '0; full = 1'b0;
      #1;
      compare_all();
      step_model();
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".a.wr_en"},   32'(if_a.wr_en), 32'd0);
      check({name, ".a.wr_data"}, if_a.wr_data,    32'd0);
      check({name, ".a.cnt"},     32'(a_cnt),      32'd0);
      check({name, ".a.ovf"},     32'(a_ovf),      32'd0);
      check({name, ".a.fs"},      32'(a_fs),       32'd0);
      check({name, ".b.wr_data"}, if_b.wr_data,    32'd0);
      check({name, ".c.wr_en"},   32'(if_c.wr_en), 32'd0);
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1; vs = 1'b0; de = 1'b0; pd = '0; full = 1'b0;
      model_reset();
      #3;
      check_all_zero("reset");
      release_reset();

      // Two pixels make one word; LSB-first and MSB-first orderings.
      cycle(0, 1, 16'h1111, 0);
      cycle(0, 1, 16'h2222, 0);
      cycle(0, 0, 16'h0000, 0);
      check("pin.lsb_en",   32'(if_a.wr_en), 32'd1);
      check("pin.lsb_data", if_a.wr_data,    32'h2222_1111);
      check("pin.msb_data", if_b.wr_data,    32'h1111_2222);
      cycle(0, 0, 16'h0000, 0);
      check("pin.cnt1", 32'(a_cnt), 32'd1);

      // Full over pixels 2..7: first word held, three later words dropped.
      for (int i = 0; i < 8; i++) cycle(0, 1, 16'h3000 + 16'(i), (i >= 2));
      cycle(0, 0, 16'h0000, 0);
      check("pin.full_en",   32'(if_a.wr_en), 32'd1);
      check("pin.full_data", if_a.wr_data,    32'h3001_3000);
      check("pin.full_ovf",  32'(a_ovf),      32'd1);
`ifdef WFIFO_PACK_DROP_CNT_EN
      check("pin.drop_cnt", 32'(a_dc), 32'd3);
`endif

      // Frame start after three pixels discards the partial word.
      cycle(0, 1, 16'h4001, 0);
      cycle(0, 1, 16'h4002, 0);
      cycle(0, 1, 16'h4003, 0);
      cycle(1, 0, 16'h0000, 0);
      cycle(1, 0, 16'h0000, 0);
      check("pin.fs_pulse", 32'(a_fs), 32'd1);
      cycle(1, 1, 16'h00AA, 0);
      check("pin.fs_once", 32'(a_fs), 32'd0);
      cycle(1, 1, 16'h00BB, 0);
      cycle(1, 0, 16'h0000, 0);
      check("pin.realign_data", if_a.wr_data, 32'h00BB_00AA);
      check("pin.realign_ovf",  32'(a_ovf),   32'd0);
      check("pin.realign_cnt0", 32'(a_cnt),   32'd0);
      cycle(1, 0, 16'h0000, 0);
      check("pin.realign_cnt1", 32'(a_cnt), 32'd1);

      // Pixel in the vs_rise cycle is lane 0 of the new frame.
      cycle(0, 0, 16'h0000, 0);
      cycle(1, 1, 16'h00CC, 0);
      cycle(1, 1, 16'h00DD, 0);
      cycle(1, 0, 16'h0000, 0);
      check("pin.vs_de_data", if_a.wr_data, 32'h00DD_00CC);

      // 20 words into the 4-bit counter saturates at 15.
      for (int i = 0; i < 40; i++) cycle(1, 1, 16'($urandom), 0);
      cycle(1, 0, 16'h0000, 0);
      cycle(1, 0, 16'h0000, 0);
      check("pin.cnt_sat", 32'(b_cnt), 32'hF);

      // Asynchronous reset mid-word with a word held by full.
      cycle(1, 1, 16'h5001, 1);
      cycle(1, 1, 16'h5002, 1);
      cycle(1, 1, 16'h5003, 1);
      @(posedge clk);
      #2;
      rst = 1'b1; vs = 1'b0; de = 1'b0; full = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      release_reset();
      cycle(0, 1, 16'h0E01, 0);
      cycle(0, 1, 16'h0E02, 0);
      cycle(0, 0, 16'h0000, 0);
      check("pin.post_rst_data", if_a.wr_data, 32'h0E02_0E01);

      // Randomised traffic against the model.
      begin
         logic v = 1'b0;
         for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) v = ~v;
            cycle(v, ($urandom_range(0, 99) < 85), 16'($urandom), ($urandom_range(0, 99) < 30));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
